// File: rtl/clksel_ctrl.sv
// clksel_ctrl: clock-mux select sequencer (gate-off, settle, sel change, settle, gate-on).
// Build macro CLKSEL_FAILOVER_EN adds an automatic switch away from a dead active clock.
module clksel_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MIN_DWELL     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  output logic sel,
  output logic gate_en,
  output logic busy,
  output logic done,
  input  logic clk_ok_a,
  input  logic clk_ok_b
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GATE_OFF = 3'd1,
    S_SWITCH   = 3'd2,
    S_SETTLE   = 3'd3,
    S_GATE_ON  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            gate_en_q, gate_en_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            target_q, target_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            fail_now_s;
  logic            fail_next_s;

`ifdef CLKSEL_FAILOVER_EN
  logic ok_a_s1_q, ok_a_s2_q, ok_a_p_q, ok_b_s1_q, ok_b_s2_q, ok_b_p_q;
  logic ok_a_s1_d, ok_a_s2_d, ok_a_p_d, ok_b_s1_d, ok_b_s2_d, ok_b_p_d;

  always_comb begin
    ok_a_s1_d = clk_ok_a;
    ok_a_s2_d = ok_a_s1_q;
    ok_a_p_d  = ok_a_s2_q;
    ok_b_s1_d = clk_ok_b;
    ok_b_s2_d = ok_b_s1_q;
    ok_b_p_d  = ok_b_s2_q;
  end

  // Synchronisers reset to "alive" so reset never provokes a failover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_a_s1_q <= 1'b1;
      ok_a_s2_q <= 1'b1;
      ok_a_p_q  <= 1'b1;
      ok_b_s1_q <= 1'b1;
      ok_b_s2_q <= 1'b1;
      ok_b_p_q  <= 1'b1;
    end else begin
      ok_a_s1_q <= ok_a_s1_d;
      ok_a_s2_q <= ok_a_s2_d;
      ok_a_p_q  <= ok_a_p_d;
      ok_b_s1_q <= ok_b_s1_d;
      ok_b_s2_q <= ok_b_s2_d;
      ok_b_p_q  <= ok_b_p_d;
    end
  end

  // fail_next predicts next cycle's trigger so the registered req_ready can yield to it.
  always_comb begin
    fail_now_s  = 1'b0;
    fail_next_s = 1'b0;
    if (sel_q) begin
      fail_now_s = !ok_b_s2_q && !ok_b_p_q && ok_a_s2_q;
    end else begin
      fail_now_s = !ok_a_s2_q && !ok_a_p_q && ok_b_s2_q;
    end
    if (sel_d) begin
      fail_next_s = !ok_b_s2_d && !ok_b_p_d && ok_a_s2_d;
    end else begin
      fail_next_s = !ok_a_s2_d && !ok_a_p_d && ok_b_s2_d;
    end
  end
`else
  logic unused_ok_s;

  always_comb begin
    fail_now_s  = 1'b0;
    fail_next_s = 1'b0;
    unused_ok_s = clk_ok_a ^ clk_ok_b;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      gate_en_q <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      target_q  <= 1'b0;
      cnt_q     <= '0;
      dwell_q   <= DWELL_MAX;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gate_en_q <= gate_en_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fail_now_s) begin
          state_d = S_GATE_OFF;
        end else if (req_valid && ready_q && (req_sel != sel_q)) begin
          state_d = S_GATE_OFF;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GATE_OFF: begin
        if (cnt_q == SET_LAST) begin
          state_d = S_SWITCH;
        end else begin
          state_d = S_GATE_OFF;
        end
      end
      S_SWITCH: state_d = S_SETTLE;
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          state_d = S_GATE_ON;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_GATE_ON: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // gate_en and done are set on entry to GATE_ON so they are visible during that cycle.
  always_comb begin
    sel_d     = sel_q;
    gate_en_d = gate_en_q;
    done_d    = 1'b0;
    target_d  = target_q;
    cnt_d     = cnt_q;
    dwell_d   = dwell_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_GATE_OFF) begin
          target_d  = fail_now_s ? ~sel_q : req_sel;
          gate_en_d = 1'b0;
          cnt_d     = '0;
        end else if (req_valid && ready_q) begin
          done_d = 1'b1;
        end else if (dwell_q < DWELL_MAX) begin
          dwell_d = dwell_q + 1'b1;
        end else begin
          dwell_d = dwell_q;
        end
      end
      S_GATE_OFF: begin
        if (cnt_q == SET_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SWITCH: begin
        sel_d = target_q;
        cnt_d = '0;
      end
      S_SETTLE: begin
        if (cnt_q == SET_LAST) begin
          gate_en_d = 1'b1;
          done_d    = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GATE_ON: begin
        gate_en_d = 1'b1;
        dwell_d   = '0;
      end
      default: begin
        gate_en_d = 1'b1;
        cnt_d     = '0;
      end
    endcase
  end

  always_comb begin
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) && (dwell_d >= DWELL_MAX) && !fail_next_s;
  end

  assign req_ready = ready_q;
  assign sel       = sel_q;
  assign gate_en   = gate_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_clksel_ctrl.sv
// Testbench for clksel_ctrl: timeline-based reference model plus directed literal checks.
// The failover scenario runs only when CLKSEL_FAILOVER_EN is defined for both files.
module tb_clksel_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic clk_ok_a = 1'b1;
  logic clk_ok_b = 1'b1;
  logic req_ready, sel, gate_en, busy, done;
  logic live = 1'b0;

  int checks = 0;
  int failures = 0;

  // model state: a switch is described by its accept cycle and target
  int  n = 0;
  int  sw_start = 0;
  int  done_cyc = 0;
  int  noop_cyc = 0;
  bit  active = 1'b0;
  bit  target = 1'b0;
  bit  base_sel = 1'b0;
  bit  has_done = 1'b0;
  bit  noop_pend = 1'b0;
  bit  ha [4];
  bit  hb [4];

  always #5 clk = ~clk;

  clksel_ctrl #(.SETTLE_CYCLES(4), .MIN_DWELL(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .sel(sel), .gate_en(gate_en), .busy(busy), .done(done),
    .clk_ok_a(clk_ok_a), .clk_ok_b(clk_ok_b)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outputs follow from the cycle offset e since accept: gate off e=1..9,
  // new sel from e=6, done at e=10; dwell allows a new accept 17 cycles after done.
  task automatic model_step();
    bit e_sel, e_gate, e_ready, e_busy, e_done, inwin, fail;
    int e;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin ha[k] = 1'b1; hb[k] = 1'b1; end
    end else begin
      for (int k = 3; k > 0; k--) begin ha[k] = ha[k-1]; hb[k] = hb[k-1]; end
      ha[0] = clk_ok_a;
      hb[0] = clk_ok_b;
    end
    if (!live) begin
      n = 0; active = 1'b0; base_sel = 1'b0; has_done = 1'b0; noop_pend = 1'b0;
      e_sel = 1'b0; e_gate = 1'b1; e_ready = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e = active ? (n - sw_start) : 0;
      inwin = active && (e >= 1) && (e <= 10);
      fail = 1'b0;
`ifdef CLKSEL_FAILOVER_EN
      if (!inwin)
        fail = base_sel ? (!hb[2] && !hb[3] && ha[2]) : (!ha[2] && !ha[3] && hb[2]);
`endif
      e_busy  = inwin;
      e_gate  = !(active && (e >= 1) && (e <= 9));
      e_sel   = (active && (e >= 6)) ? target : base_sel;
      e_done  = (active && (e == 10)) || (noop_pend && (n == noop_cyc + 1));
      e_ready = !inwin && !fail && (!has_done || (n >= done_cyc + 17));
      if (noop_pend && (n == noop_cyc + 1)) noop_pend = 1'b0;
      if (active && (e == 10)) begin
        base_sel = target; active = 1'b0; has_done = 1'b1; done_cyc = n;
      end
      if (fail) begin
        active = 1'b1; sw_start = n; target = !base_sel;
      end else if (e_ready && req_valid) begin
        if (req_sel != base_sel) begin
          active = 1'b1; sw_start = n; target = req_sel;
        end else begin
          noop_pend = 1'b1; noop_cyc = n;
        end
      end
      n++;
    end
    check("model_sel", sel, e_sel);
    check("model_gate_en", gate_en, e_gate);
    check("model_req_ready", req_ready, e_ready);
    check("model_busy", busy, e_busy);
    check("model_done", done, e_done);
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    while (!done && c < 40) begin step(); c++; end
    check(name, done, 1);
  endtask

  task automatic count_not_ready(output int c);
    c = 0;
    step();
    while (!req_ready && c < 40) begin c++; step(); end
  endtask

  initial begin
    int cnt;
    int dn;
    fork
      begin
        forever begin
          @(negedge clk);
          model_step();
        end
      end
    join_none

    // 1: reset values, then first cycle after release
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("rst_sel", sel, 0);
    check("rst_gate_en", gate_en, 1);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step();
    check("t1_req_ready", req_ready, 1);
    check("t1_done", done, 0);
    check("t1_sel", sel, 0);

    // 2: switch to clk_b, accept at cycle T
    req_valid = 1'b1; req_sel = 1'b1;
    step(); req_valid = 1'b0;
    check("t2_gate_T1", gate_en, 0);
    check("t2_busy_T1", busy, 1);
    repeat (4) step();
    check("t2_sel_T5", sel, 0);
    step();
    check("t2_sel_T6", sel, 1);
    check("t2_gate_T6", gate_en, 0);
    repeat (4) step();
    check("t2_gate_T10", gate_en, 1);
    check("t2_done_T10", done, 1);

    // 3: same clock again, blocked by dwell, then a no-op
    req_valid = 1'b1; req_sel = 1'b1;
    count_not_ready(cnt);
    check("t3_dwell_cycles", cnt, 16);
    step(); req_valid = 1'b0;
    check("t3_noop_done", done, 1);
    check("t3_noop_sel", sel, 1);
    check("t3_noop_gate", gate_en, 1);
    dn = 0;
    repeat (8) begin step(); dn += int'(done); end
    check("t3_extra_done", dn, 0);

    // 4: reset in the middle of SETTLE
    req_valid = 1'b1; req_sel = 1'b0;
    step(); req_valid = 1'b0;
    repeat (6) step();
    check("t4_pre_gate", gate_en, 0);
    check("t4_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_async_sel", sel, 0);
    check("t4_async_gate", gate_en, 1);
    check("t4_async_busy", busy, 0);
    req_valid = 1'b1; req_sel = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("t4_ready_first", req_ready, 1);
    step();
    check("t4_accepted", gate_en, 0);

    // 5: opposite request held during the switch, runs after dwell
    req_sel = 1'b0;
    wait_done("t5_first_done");
    check("t5_first_sel", sel, 1);
    count_not_ready(cnt);
    check("t5_dwell_cycles", cnt, 16);
    step(); req_valid = 1'b0;
    check("t5_second_gate", gate_en, 0);
    check("t5_second_busy", busy, 1);
    wait_done("t5_second_done");
    check("t5_second_sel", sel, 0);
    repeat (2) step();

`ifdef CLKSEL_FAILOVER_EN
    // 6: active clock dies, other alive -> automatic switch
    clk_ok_a = 1'b0; clk_ok_b = 1'b1;
    step(); cnt = 1;
    while (gate_en && cnt < 10) begin step(); cnt++; end
    check("t6_fo_within_4", int'(cnt <= 4), 1);
    wait_done("t6_fo_done");
    check("t6_fo_sel", sel, 1);
    clk_ok_b = 1'b0;
    repeat (12) step();
    check("t6_no_switch_busy", busy, 0);
    check("t6_no_switch_sel", sel, 1);
    clk_ok_a = 1'b1; clk_ok_b = 1'b1;
    repeat (4) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
